// File: rtl/sram_arb_pkg.sv
// Shared widths and request bundle for the two-port SRAM arbiter.
// Widths default to the 256x32 macro with byte-lane write masks.
package sram_arb_pkg;

    localparam int SRAM_DW = 32;
    localparam int SRAM_AW = 8;
    localparam int SRAM_MW = SRAM_DW / 8;

    typedef logic port_id_t;

    typedef struct packed {
        logic               we;
        logic [SRAM_MW-1:0] wmask;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers the last granted port.
// Latency: grant is combinational from the valids, state updates on grant.
// Backpressure: none internally; the losing valid simply waits.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    output logic [1:0] gnt,
    output logic       gnt_vld
);

    port_id_t last_grant_q;
    port_id_t win_id;

    always_comb begin
        win_id = 1'b0;
        if (valid0 && valid1) begin
            win_id = ~last_grant_q;
        end else if (valid1) begin
            win_id = 1'b1;
        end
        gnt_vld = valid0 | valid1;
        gnt     = 2'b00;
        if (gnt_vld) begin
            gnt = win_id ? 2'b10 : 2'b01;
        end
    end

    // Reset to port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (gnt_vld) begin
            last_grant_q <= win_id;
        end
    end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Round-robin sequencer sharing one single-port SRAM macro between two clients.
// Latency: request reaches the macro combinationally; read data returns 1 cycle after accept.
// Backpressure: req_ready is the grant; responses have no backpressure.
module sram_arbiter_2p
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = SRAM_DW,
    parameter int ADDR_WIDTH  = SRAM_AW,
    parameter int WMASK_WIDTH = SRAM_MW
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   p0_req_valid,
    output logic                   p0_req_ready,
    input  logic                   p0_we,
    input  logic [WMASK_WIDTH-1:0] p0_wmask,
    input  logic [ADDR_WIDTH-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    output logic                   p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]  p0_rdata,

    input  logic                   p1_req_valid,
    output logic                   p1_req_ready,
    input  logic                   p1_we,
    input  logic [WMASK_WIDTH-1:0] p1_wmask,
    input  logic [ADDR_WIDTH-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    output logic                   p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]  p1_rdata,

    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    req_t       p0_req;
    req_t       p1_req;
    req_t       win_req;
    logic [1:0] gnt;
    logic       gnt_vld;
    port_id_t   win_id;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rsp_pend_q;
    port_id_t              rsp_port_q;

    assign p0_req = '{we: p0_we, wmask: p0_wmask, addr: p0_addr, wdata: p0_wdata};
    assign p1_req = '{we: p1_we, wmask: p1_wmask, addr: p1_addr, wdata: p1_wdata};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid0  (p0_req_valid),
        .valid1  (p1_req_valid),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    assign win_id       = gnt[1];
    assign win_req      = win_id ? p1_req : p0_req;
    assign p0_req_ready = gnt[0];
    assign p1_req_ready = gnt[1];

    // Idle cycles replay the last address/data so the macro pins stay quiet.
    assign sram_we    = gnt_vld & win_req.we;
    assign sram_wmask = gnt_vld ? win_req.wmask : '0;
    assign sram_addr  = gnt_vld ? win_req.addr  : addr_q;
    assign sram_din   = gnt_vld ? win_req.wdata : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            din_q      <= '0;
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
        end else begin
            rsp_pend_q <= gnt_vld & ~win_req.we;
            if (gnt_vld) begin
                addr_q     <= win_req.addr;
                din_q      <= win_req.wdata;
                rsp_port_q <= win_id;
            end
        end
    end

    assign p0_rsp_valid = rsp_pend_q && (rsp_port_q == 1'b0);
    assign p1_rsp_valid = rsp_pend_q && (rsp_port_q == 1'b1);
    assign p0_rdata     = sram_dout;
    assign p1_rdata     = sram_dout;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a behavioural 256x32 byte-masked SRAM.
module tb_sram_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid;
    logic [3:0]  p0_wmask;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid;
    logic [3:0]  p1_wmask;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_2p dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
        .p0_wmask(p0_wmask), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
        .p1_wmask(p1_wmask), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Macro model: byte-masked write at the edge, registered read otherwise.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [3:0] m,
                          input logic [7:0] a, input logic [31:0] d);
        p0_req_valid = v; p0_we = we; p0_wmask = m; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [3:0] m,
                          input logic [7:0] a, input logic [31:0] d);
        p1_req_valid = v; p1_we = we; p1_wmask = m; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        #12;
        chk("rst_p0_ready", 32'(p0_req_ready), 32'h0);
        chk("rst_sram_we", 32'(sram_we), 32'h0);
        chk("rst_sram_wmask", 32'(sram_wmask), 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("idle_p0_ready", 32'(p0_req_ready), 32'h0);
        chk("idle_p1_ready", 32'(p1_req_ready), 32'h0);
        chk("idle_p0_rsp", 32'(p0_rsp_valid), 32'h0);
        chk("idle_p1_rsp", 32'(p1_rsp_valid), 32'h0);
        chk("idle_din", sram_din, 32'h0);

        // p0 write then read of 0x10
        set_p0(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        #1;
        chk("wr_p0_ready", 32'(p0_req_ready), 32'h1);
        chk("wr_p1_ready", 32'(p1_req_ready), 32'h0);
        chk("wr_sram_we", 32'(sram_we), 32'h1);
        chk("wr_sram_addr", 32'(sram_addr), 32'h10);
        chk("wr_sram_din", sram_din, 32'hDEADBEEF);
        chk("wr_sram_wmask", 32'(sram_wmask), 32'hF);
        cyc();
        chk("wr_no_rsp", 32'(p0_rsp_valid), 32'h0);
        set_p0(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        #1;
        chk("rd_sram_we", 32'(sram_we), 32'h0);
        cyc();
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        chk("rd_p0_rsp", 32'(p0_rsp_valid), 32'h1);
        chk("rd_p0_data", p0_rdata, 32'hDEADBEEF);
        chk("rd_p1_rsp", 32'(p1_rsp_valid), 32'h0);
        cyc();
        chk("rd_rsp_clear", 32'(p0_rsp_valid), 32'h0);

        // Byte-masked overwrite
        set_p0(1'b1, 1'b1, 4'hF, 8'h20, 32'h11223344);
        cyc();
        set_p0(1'b1, 1'b1, 4'b0101, 8'h20, 32'hAABBCCDD);
        cyc();
        set_p0(1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
        cyc();
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        chk("mask_rsp", 32'(p0_rsp_valid), 32'h1);
        chk("mask_data", p0_rdata, 32'h11BB33DD);

        // Seed addrs 1 and 2; the p1 write leaves last grant at 1
        set_p0(1'b1, 1'b1, 4'hF, 8'h01, 32'h01010101);
        cyc();
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_p1(1'b1, 1'b1, 4'hF, 8'h02, 32'h02020202);
        cyc();

        // Contention: both hold reads for 6 cycles
        set_p0(1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        set_p1(1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont%0d_p0_ready", i), 32'(p0_req_ready), 32'((i % 2) == 0));
            chk($sformatf("cont%0d_p1_ready", i), 32'(p1_req_ready), 32'((i % 2) == 1));
            chk($sformatf("cont%0d_addr", i), 32'(sram_addr), (i % 2) ? 32'h2 : 32'h1);
            cyc();
            chk($sformatf("cont%0d_p0_rsp", i), 32'(p0_rsp_valid), 32'((i % 2) == 0));
            chk($sformatf("cont%0d_p1_rsp", i), 32'(p1_rsp_valid), 32'((i % 2) == 1));
            chk($sformatf("cont%0d_data", i), (i % 2) ? p1_rdata : p0_rdata,
                (i % 2) ? 32'h02020202 : 32'h01010101);
        end
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();

        // Cross-port write-then-read
        set_p1(1'b1, 1'b1, 4'hF, 8'h30, 32'h5A5A5A5A);
        cyc();
        set_p1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_p0(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        cyc();
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        chk("xport_p0_rsp", 32'(p0_rsp_valid), 32'h1);
        chk("xport_data", p0_rdata, 32'h5A5A5A5A);
        chk("xport_p1_rsp", 32'(p1_rsp_valid), 32'h0);

        // p1 read accepted, then reset before the next edge
        set_p1(1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        cyc();
        set_p1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_p1_rsp", 32'(p1_rsp_valid), 32'h0);
        chk("rstmid_addr", 32'(sram_addr), 32'h0);
        cyc();
        chk("rstmid_p1_rsp_next", 32'(p1_rsp_valid), 32'h0);
        #2;
        rst_n = 1'b1;
        set_p0(1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        set_p1(1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        #1;
        chk("rstmid_first_p0", 32'(p0_req_ready), 32'h1);
        chk("rstmid_first_p1", 32'(p1_req_ready), 32'h0);
        cyc();
        chk("rstmid_after_p1_rsp", 32'(p1_rsp_valid), 32'h0);
        chk("rstmid_after_p0_rsp", 32'(p0_rsp_valid), 32'h1);
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();

        // Idle hold after a write to 0x7F
        set_p0(1'b1, 1'b1, 4'hF, 8'h7F, 32'h77777777);
        cyc();
        set_p0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold%0d_addr", i), 32'(sram_addr), 32'h7F);
            chk($sformatf("hold%0d_din", i), sram_din, 32'h77777777);
            chk($sformatf("hold%0d_we", i), 32'(sram_we), 32'h0);
            chk($sformatf("hold%0d_wmask", i), 32'(sram_wmask), 32'h0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
